// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: ID-stage load-use stall, branch flush and EX/MEM/WB operand forwarding
// built on a shadow pipeline of destination-register info, with saturating event counters.
module hazard_fwd_unit #(
    parameter int CNT_W = 16
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst_n,
    input  logic [4:0]       rR1_ID,
    input  logic [4:0]       rR2_ID,
    input  logic             re1_ID,
    input  logic             re2_ID,
    input  logic [4:0]       wR_ID,
    input  logic             rf_we_ID,
    input  logic             is_load_ID,
    input  logic             branch_taken_EX,
    input  logic [31:0]      wd_EX,
    input  logic [31:0]      wd_MEM,
    input  logic [31:0]      wd_WB,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             nop,
    output logic             forward_en_rD1,
    output logic             forward_en_rD2,
    output logic [31:0]      forward_rD1,
    output logic [31:0]      forward_rD2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef struct packed {
        logic       v;
        logic [4:0] wr;
        logic       we;
        logic       ld;
    } slot_t;

    slot_t             r_ex, r_mem, r_wb;
    logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
    logic              w_ex1, w_ex2, w_mem1, w_mem2, w_wb1, w_wb2;
    logic              w_fex1, w_fex2, w_lu, w_stall, w_flush;

    // x0 is excluded on both the reader and the writer side
    function automatic logic hit(input slot_t s, input logic re, input logic [4:0] r);
        return re && (r != 5'd0) && s.v && s.we && (s.wr == r);
    endfunction

    always_comb begin
        w_ex1   = hit(r_ex, re1_ID, rR1_ID);
        w_ex2   = hit(r_ex, re2_ID, rR2_ID);
        w_mem1  = hit(r_mem, re1_ID, rR1_ID);
        w_mem2  = hit(r_mem, re2_ID, rR2_ID);
        w_wb1   = hit(r_wb, re1_ID, rR1_ID);
        w_wb2   = hit(r_wb, re2_ID, rR2_ID);
        w_fex1  = w_ex1 && !r_ex.ld;
        w_fex2  = w_ex2 && !r_ex.ld;
        w_lu    = (w_ex1 || w_ex2) && r_ex.ld;
        w_flush = cpu_rst_n && branch_taken_EX;
        w_stall = cpu_rst_n && w_lu && !branch_taken_EX;
    end

    always_comb begin
        stall_pc       = w_stall;
        stall_if_id    = w_stall;
        flush_if_id    = w_flush;
        nop            = w_stall || w_flush;
        forward_en_rD1 = w_fex1 || w_mem1 || w_wb1;
        forward_en_rD2 = w_fex2 || w_mem2 || w_wb2;
        forward_rD1    = w_fex1 ? wd_EX : w_mem1 ? wd_MEM : w_wb1 ? wd_WB : 32'd0;
        forward_rD2    = w_fex2 ? wd_EX : w_mem2 ? wd_MEM : w_wb2 ? wd_WB : 32'd0;
        stall_cnt      = r_stall_cnt;
        flush_cnt      = r_flush_cnt;
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_ex        <= nop ? slot_t'('0) : slot_t'{1'b1, wR_ID, rf_we_ID, is_load_ID};
            r_mem       <= r_ex;
            r_wb        <= r_mem;
            r_stall_cnt <= (w_stall && r_stall_cnt != '1) ? r_stall_cnt + 1'b1 : r_stall_cnt;
            r_flush_cnt <= (w_flush && r_flush_cnt != '1) ? r_flush_cnt + 1'b1 : r_flush_cnt;
        end
    end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed and random stimulus, expected outputs from a history-based
// model are queued and checked by an independent monitor one step after each drive.
module tb_hazard_fwd_unit;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    r1, r2, wr;
    logic          re1, re2, we, ld, br;
    logic [31:0]   wde, wdm, wdw;
    logic          spc, sif, fif, nop, en1, en2;
    logic [31:0]   f1, f2;
    logic [CW-1:0] scnt, fcnt;

    typedef struct packed {
        logic          spc, sif, fif, nop, en1, en2;
        logic [31:0]   f1, f2;
        logic [CW-1:0] sc, fc;
    } exp_t;

    typedef struct {
        bit v;
        int wr;
        bit we;
        bit ld;
    } instr_t;

    exp_t   sb[$];
    instr_t hist[3];
    int     m_sc, m_fc;
    int     n_chk = 0, n_fail = 0;

    hazard_fwd_unit #(.CNT_W(CW)) dut (
        .cpu_clk(clk), .cpu_rst_n(rst_n),
        .rR1_ID(r1), .rR2_ID(r2), .re1_ID(re1), .re2_ID(re2),
        .wR_ID(wr), .rf_we_ID(we), .is_load_ID(ld), .branch_taken_EX(br),
        .wd_EX(wde), .wd_MEM(wdm), .wd_WB(wdw),
        .stall_pc(spc), .stall_if_id(sif), .flush_if_id(fif), .nop(nop),
        .forward_en_rD1(en1), .forward_en_rD2(en2),
        .forward_rD1(f1), .forward_rD2(f2),
        .stall_cnt(scnt), .flush_cnt(fcnt)
    );

    always #5 clk = ~clk;

    // hist[0] is the youngest instruction issued past ID (EX), hist[2] the oldest (WB)
    task automatic operand(input int a, input bit e, input logic [31:0] wd[3],
                           output bit en, output logic [31:0] val, output bit lu);
        en = 0; val = 0; lu = 0;
        for (int age = 0; age < 3; age++)
            if (e && a != 0 && hist[age].v && hist[age].we && hist[age].wr == a) begin
                if (age == 0 && hist[0].ld) lu = 1;
                else if (!en) begin en = 1; val = wd[age]; end
            end
    endtask

    task automatic step(input bit rn, input int a1, a2, input bit e1, e2,
                        input int w, input bit wen, l, b,
                        input logic [31:0] x, m, y);
        exp_t        ex;
        logic [31:0] wd[3];
        logic [31:0] v1, v2;
        bit          k1, k2, lu1, lu2, stall, bub;
        @(negedge clk);
        rst_n = rn; r1 = 5'(a1); r2 = 5'(a2); re1 = e1; re2 = e2;
        wr = 5'(w); we = wen; ld = l; br = b; wde = x; wdm = m; wdw = y;
        wd[0] = x; wd[1] = m; wd[2] = y;
        ex = '0;
        if (!rn) begin
            for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0};
            m_sc = 0; m_fc = 0;
            sb.push_back(ex);
        end else begin
            operand(a1, e1, wd, k1, v1, lu1);
            operand(a2, e2, wd, k2, v2, lu2);
            stall = (lu1 || lu2) && !b;
            bub = stall || b;
            ex = '{stall, stall, b, bub, k1, k2, v1, v2, CW'(m_sc), CW'(m_fc)};
            sb.push_back(ex);
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = bub ? '{0, 0, 0, 0} : '{1, w, wen, l};
            if (stall) m_sc = (m_sc + 1 > 15) ? 15 : m_sc + 1;
            if (b) m_fc = (m_fc + 1 > 15) ? 15 : m_fc + 1;
        end
    endtask

    always @(negedge clk) begin
        exp_t want, got;
        #2;
        if (sb.size() != 0) begin
            want = sb.pop_front();
            got = '{spc, sif, fif, nop, en1, en2, f1, f2, scnt, fcnt};
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL outputs chk%0d: got %h want %h", n_chk, got, want);
            end
        end
    end

    initial begin
        rst_n = 0; r1 = 0; r2 = 0; re1 = 0; re2 = 0; wr = 0; we = 0; ld = 0; br = 0;
        wde = 0; wdm = 0; wdw = 0;
        for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0};
        m_sc = 0; m_fc = 0;
        repeat (5) step(0, $urandom_range(31), $urandom_range(31), 1'($urandom), 1'($urandom),
                        $urandom_range(31), 1'($urandom), 1'($urandom), 1'($urandom),
                        $urandom, $urandom, $urandom);
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 2, 3);
        step(1, 6, 6, 1, 1, 0, 0, 0, 0, 4, 5, 6);
        // EX -> MEM -> WB forwarding of x5
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        step(1, 5, 0, 1, 0, 0, 0, 0, 0, 32'h1234, 7, 8);
        step(1, 5, 0, 1, 0, 0, 0, 0, 0, 9, 32'hAAAA, 8);
        step(1, 5, 0, 1, 0, 0, 0, 0, 0, 9, 10, 32'h5555);
        // load-use on rR2 then MEM forward
        step(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0);
        step(1, 0, 7, 0, 1, 0, 0, 0, 0, 11, 12, 13);
        step(1, 0, 7, 0, 1, 0, 0, 0, 0, 11, 32'hBEEF, 13);
        // priority EX over WB, and x0
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        step(1, 3, 3, 1, 1, 0, 0, 0, 0, 1, 9, 2);
        step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 1, 0, 0, 21, 22, 23);
        // branch overrides load-use
        step(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0);
        step(1, 9, 9, 1, 1, 4, 1, 0, 1, 24, 25, 26);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 27, 28, 29);
        // reset in the middle of a pending load-use
        step(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0);
        step(0, 8, 8, 1, 1, 0, 0, 0, 1, 30, 31, 32);
        step(1, 8, 8, 1, 1, 0, 0, 0, 0, 33, 34, 35);
        // back-to-back loads that use x7: a stall every other cycle, drives saturation
        repeat (60) step(1, 7, 0, 1, 0, 7, 1, 1, 0, $urandom, $urandom, $urandom);
        repeat (500) step($urandom_range(99) != 0, $urandom_range(7), $urandom_range(7),
                          1'($urandom), 1'($urandom), $urandom_range(7), 1'($urandom),
                          $urandom_range(2) == 0, $urandom_range(9) == 0,
                          $urandom, $urandom, $urandom);
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        #3;
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
